// File: rtl/block_lock_66.sv
// 64b/66b block-lock FSM. Watches the sync header of each 66-bit word from the gearbox.
// While alignment is not found it asks the gearbox for one-bit slips. Once headers are
// stable it declares block lock. Words are forwarded, registered, to the descrambler.
module block_lock_66 #(
   parameter int unsigned LOCK_CNT     = 64,
   parameter int unsigned WINDOW       = 64,
   parameter int unsigned BAD_LIMIT    = 16,
   parameter int unsigned SLIP_HOLDOFF = 4,
   parameter int unsigned ERR_W        = 16
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic [65:0]       din,
   input  logic              din_valid,
   output logic              slip,
   output logic              block_lock,
   output logic [65:0]       dout,
   output logic              dout_valid,
   output logic              hdr_err,
   output logic [ERR_W-1:0]  err_count,
   input  logic              err_clear
);

   localparam int unsigned ShW   = $clog2(LOCK_CNT + 1);
   localparam int unsigned WinW  = $clog2(WINDOW + 1);
   localparam int unsigned BadW  = $clog2(BAD_LIMIT + 1);
   localparam int unsigned HoldW = $clog2(SLIP_HOLDOFF + 1);

   typedef enum logic [1:0] {StHunt, StSlip, StHoldoff, StLocked} state_e;

   state_e             state_q;
   logic [ShW-1:0]     sh_cnt_q;
   logic [WinW-1:0]    win_cnt_q;
   logic [BadW-1:0]    bad_cnt_q;
   logic [HoldW-1:0]   hold_cnt_q;

   logic hdr_good;
   logic hdr_bad_valid;

   // 01 and 10 are the only legal sync headers
   assign hdr_good      = din[1] ^ din[0];
   assign hdr_bad_valid = din_valid & ~hdr_good;

   // Registered pass-through; header error flagged in the same output cycle as the word
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         hdr_err    <= 1'b0;
      end else begin
         dout       <= din;
         dout_valid <= din_valid;
         // Headers are unreliable while the gearbox realigns after a slip
         hdr_err    <= hdr_bad_valid && (state_q != StHoldoff);
      end
   end

   // Lock FSM with its counters and registered slip/block_lock outputs
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= StHunt;
         sh_cnt_q   <= '0;
         win_cnt_q  <= '0;
         bad_cnt_q  <= '0;
         hold_cnt_q <= '0;
         slip       <= 1'b0;
         block_lock <= 1'b0;
      end else begin
         unique case (state_q)
            StHunt: begin
               if (din_valid) begin
                  if (!hdr_good) begin
                     state_q  <= StSlip;
                     sh_cnt_q <= '0;
                     slip     <= 1'b1;
                  end else if (sh_cnt_q == ShW'(LOCK_CNT - 1)) begin
                     state_q    <= StLocked;
                     sh_cnt_q   <= '0;
                     win_cnt_q  <= '0;
                     bad_cnt_q  <= '0;
                     block_lock <= 1'b1;
                  end else begin
                     sh_cnt_q <= sh_cnt_q + ShW'(1);
                  end
               end
            end
            StSlip: begin
               // Single-cycle pulse; the word arriving now is not part of the holdoff
               state_q    <= StHoldoff;
               hold_cnt_q <= '0;
               slip       <= 1'b0;
            end
            StHoldoff: begin
               if (din_valid) begin
                  if (hold_cnt_q == HoldW'(SLIP_HOLDOFF - 1)) begin
                     state_q    <= StHunt;
                     hold_cnt_q <= '0;
                     sh_cnt_q   <= '0;
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HoldW'(1);
                  end
               end
            end
            StLocked: begin
               if (din_valid) begin
                  // Loss of lock wins over a window rollover on the same word
                  if (!hdr_good && (bad_cnt_q == BadW'(BAD_LIMIT - 1))) begin
                     state_q    <= StSlip;
                     win_cnt_q  <= '0;
                     bad_cnt_q  <= '0;
                     slip       <= 1'b1;
                     block_lock <= 1'b0;
                  end else if (win_cnt_q == WinW'(WINDOW - 1)) begin
                     win_cnt_q <= '0;
                     bad_cnt_q <= '0;
                  end else begin
                     win_cnt_q <= win_cnt_q + WinW'(1);
                     if (!hdr_good) begin
                        bad_cnt_q <= bad_cnt_q + BadW'(1);
                     end
                  end
               end
            end
            default: begin
               state_q    <= StHunt;
               slip       <= 1'b0;
               block_lock <= 1'b0;
            end
         endcase
      end
   end

   // Saturating bad-header counter, only while locked; clear beats increment
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_count <= '0;
      end else if (err_clear) begin
         err_count <= '0;
      end else if ((state_q == StLocked) && hdr_bad_valid && (err_count != {ERR_W{1'b1}})) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

`ifndef SYNTHESIS
   // Parameter legality
   a_params_legal : assert property (@(posedge clk)
      (LOCK_CNT >= 1) && (BAD_LIMIT >= 1) && (WINDOW >= BAD_LIMIT) && (SLIP_HOLDOFF >= 1));
`endif

endmodule

// File: tb/tb_block_lock_66.sv
// Directed bench for block_lock_66. ERR_W is reduced to 5 so that saturation of
// err_count is reachable (31 = all-ones) in a short run.
module tb_block_lock_66;

   localparam int unsigned ErrW = 5;

   logic            clk;
   logic            arst_n;
   logic [65:0]     din;
   logic            din_valid;
   logic            slip;
   logic            block_lock;
   logic [65:0]     dout;
   logic            dout_valid;
   logic            hdr_err;
   logic [ErrW-1:0] err_count;
   logic            err_clear;

   int n_vec;
   int n_err;
   int slip_seen;
   int herr_seen;

   block_lock_66 #(
      .LOCK_CNT     (64),
      .WINDOW       (64),
      .BAD_LIMIT    (16),
      .SLIP_HOLDOFF (4),
      .ERR_W        (ErrW)
   ) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .din        (din),
      .din_valid  (din_valid),
      .slip       (slip),
      .block_lock (block_lock),
      .dout       (dout),
      .dout_valid (dout_valid),
      .hdr_err    (hdr_err),
      .err_count  (err_count),
      .err_clear  (err_clear)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one word for one clock, then sample #1 after the edge
   task automatic send(input logic [1:0] hdr, input logic v, input logic clr);
      logic [65:0] w;
      w[65:34]  = $urandom;
      w[33:2]   = $urandom;
      w[1:0]    = hdr;
      din       = w;
      din_valid = v;
      err_clear = clr;
      @(posedge clk);
      #1;
      chk("dout", dout, w);
      chk("dout_valid", {65'd0, dout_valid}, {65'd0, v});
      if (slip) slip_seen++;
      if (hdr_err) herr_seen++;
      err_clear = 1'b0;
   endtask

   task automatic good_words(input int n);
      for (int i = 0; i < n; i++) send(2'b01, 1'b1, 1'b0);
   endtask

   // Reset asserted between edges; outputs must clear before the next edge
   task automatic do_reset();
      din_valid = 1'b0;
      err_clear = 1'b0;
      arst_n    = 1'b0;
      #2;
      chk("rst_slip", slip, 1'b0);
      chk("rst_lock", block_lock, 1'b0);
      chk("rst_dout", dout, 66'd0);
      chk("rst_dout_valid", dout_valid, 1'b0);
      chk("rst_hdr_err", hdr_err, 1'b0);
      chk("rst_err_count", err_count, 66'd0);
      #2;
      arst_n = 1'b1;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      arst_n    = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      err_clear = 1'b0;
      @(posedge clk);
      #1;
      chk("init_slip", slip, 1'b0);
      chk("init_lock", block_lock, 1'b0);
      chk("init_dout", dout, 66'd0);
      chk("init_dout_valid", dout_valid, 1'b0);
      chk("init_hdr_err", hdr_err, 1'b0);
      chk("init_err_count", err_count, 66'd0);
      arst_n = 1'b1;

      // Clean acquisition: 64 good headers
      slip_seen = 0;
      herr_seen = 0;
      good_words(63);
      chk("acq_lock_early", block_lock, 1'b0);
      good_words(1);
      chk("acq_lock", block_lock, 1'b1);
      chk("acq_no_slip", slip_seen, 0);
      chk("acq_no_hdr_err", herr_seen, 0);

      // Reset mid-lock, then a bad header at word 10 in HUNT
      do_reset();
      good_words(9);
      send(2'b11, 1'b1, 1'b0);
      chk("hunt_hdr_err", hdr_err, 1'b1);
      chk("hunt_slip", slip, 1'b1);
      chk("hunt_lock", block_lock, 1'b0);
      send(2'b11, 1'b0, 1'b0);
      chk("slip_one_cycle", slip, 1'b0);
      chk("slip_cycle_hdr_err", hdr_err, 1'b0);
      slip_seen = 0;
      herr_seen = 0;
      for (int i = 0; i < 4; i++) send(2'b00, 1'b1, 1'b0);
      chk("holdoff_no_slip", slip_seen, 0);
      chk("holdoff_no_hdr_err", herr_seen, 0);
      good_words(63);
      chk("reacq_lock_early", block_lock, 1'b0);
      good_words(1);
      chk("reacq_lock", block_lock, 1'b1);
      chk("reacq_err_count", err_count, 66'd0);

      // Window 1: 15 bad headers (words 2,6,...,58) keeps lock
      slip_seen = 0;
      herr_seen = 0;
      for (int i = 0; i < 64; i++) begin
         send(((i % 4 == 1) && (i < 60)) ? 2'b11 : 2'b01, 1'b1, 1'b0);
      end
      chk("win1_lock", block_lock, 1'b1);
      chk("win1_err_count", err_count, 66'd15);
      chk("win1_hdr_err_pulses", herr_seen, 15);
      chk("win1_no_slip", slip_seen, 0);

      // Window 2: 16 bad headers, the 16th on the last word of the window
      for (int i = 0; i < 63; i++) begin
         send((i % 4 == 3) ? 2'b00 : 2'b10, 1'b1, 1'b0);
      end
      chk("win2_lock_held", block_lock, 1'b1);
      chk("win2_no_slip", slip_seen, 0);
      chk("win2_err_count_30", err_count, 66'd30);
      send(2'b00, 1'b1, 1'b0);
      chk("lol_lock", block_lock, 1'b0);
      chk("lol_slip", slip, 1'b1);
      chk("lol_hdr_err", hdr_err, 1'b1);
      chk("lol_err_count", err_count, 66'd31);

      // SLIP cycle, holdoff, then acquisition with din_valid toggling
      send(2'b01, 1'b0, 1'b0);
      chk("lol_slip_end", slip, 1'b0);
      for (int i = 0; i < 4; i++) send(2'b11, 1'b1, 1'b0);
      slip_seen = 0;
      herr_seen = 0;
      for (int k = 0; k < 64; k++) begin
         send(2'b01, 1'b1, 1'b0);
         if (k == 63) chk("tog_lock", block_lock, 1'b1);
         send(2'b11, 1'b0, 1'b0);
         if (k == 62) chk("tog_lock_early", block_lock, 1'b0);
      end
      chk("tog_lock_hold", block_lock, 1'b1);
      chk("tog_no_slip", slip_seen, 0);
      chk("tog_no_hdr_err", herr_seen, 0);
      chk("err_count_kept", err_count, 66'd31);

      // Saturation, clear priority, 2'b10 is good
      send(2'b00, 1'b1, 1'b0);
      chk("sat_err_count", err_count, 66'd31);
      chk("sat_hdr_err", hdr_err, 1'b1);
      send(2'b11, 1'b1, 1'b1);
      chk("clear_prio", err_count, 66'd0);
      send(2'b00, 1'b1, 1'b0);
      chk("after_clear_inc", err_count, 66'd1);
      send(2'b10, 1'b1, 1'b0);
      chk("hdr10_good", hdr_err, 1'b0);
      chk("hdr10_lock", block_lock, 1'b1);

      // Asynchronous reset while locked with a non-zero error count
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
